bandai_unlock_rx: RTL and testbench



---
 rtl/bandai_pkg.sv | 16 +
 rtl/bandai_unlock_rx.sv | 155 +++++++++++++++
 tb/tb_bandai_unlock_rx.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bandai_pkg.sv
// Shared constants and FSM state type for the Bandai 2003 cartridge unlock receiver.
package bandai_pkg;

  localparam logic [7:0]  ADDR_UNLOCK_REQ = 8'hA5;
  localparam logic [17:0] UNLOCK_WORD     = 18'h05140;
  localparam int          UNLOCK_BITS     = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRST,
    ST_REQ,
    ST_SHIFT,
    ST_CHECK
  } state_e;

endpackage

// File: rtl/bandai_unlock_rx.sv
// Console-side receiver for the Bandai 2003 unlock handshake; sets sticky UNLOCKED (SYSTEM_CTRL1 bit 7).
// BANDAI_UNLOCK_CART_RESET_EN adds a CART_RST pulse (CRST state) before every handshake.
//
// state | meaning
// IDLE  | waiting for START
// CRST  | CART_RST held high to re-arm the cartridge (macro builds only)
// REQ   | one cycle presenting the unlock-request address
// SHIFT | 18 cycles capturing SI, LSB first
// CHECK | compare captured word; result registered on exit
module bandai_unlock_rx
  import bandai_pkg::*;
#(
  parameter logic [17:0] PATTERN         = UNLOCK_WORD,
  parameter int          CART_RST_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        SI,
  output logic [7:0]  ADDR_O,
  output logic        CART_RST,
  output logic        BUSY,
  output logic        DONE,
  output logic        FAIL,
  output logic        UNLOCKED,
  output logic [17:0] RX_WORD
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [17:0] shreg_q, shreg_d;
  logic [7:0]  addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic        unl_q, unl_d;
  logic [17:0] rx_q, rx_d;

`ifdef BANDAI_UNLOCK_CART_RESET_EN
  localparam int CRST_W = (CART_RST_CYCLES > 1) ? $clog2(CART_RST_CYCLES) : 1;
  logic [CRST_W-1:0] crst_cnt_q, crst_cnt_d;
  logic              crst_q, crst_d;
  assign CART_RST = crst_q;
`else
  logic unused_crst_cfg;
  assign unused_crst_cfg = (CART_RST_CYCLES > 0);
  assign CART_RST        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    addr_d  = 8'h00;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    unl_d   = unl_q;
    rx_d    = rx_q;
`ifdef BANDAI_UNLOCK_CART_RESET_EN
    crst_cnt_d = crst_cnt_q;
    crst_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          busy_d = 1'b1;
`ifdef BANDAI_UNLOCK_CART_RESET_EN
          state_d    = ST_CRST;
          crst_d     = 1'b1;
          crst_cnt_d = CRST_W'(CART_RST_CYCLES - 1);
`else
          state_d = ST_REQ;
          addr_d  = ADDR_UNLOCK_REQ;
`endif
        end
      end
      ST_CRST: begin
`ifdef BANDAI_UNLOCK_CART_RESET_EN
        if (crst_cnt_q == '0) begin
          state_d = ST_REQ;
          addr_d  = ADDR_UNLOCK_REQ;
        end else begin
          crst_cnt_d = crst_cnt_q - CRST_W'(1);
          crst_d     = 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_REQ: begin
        state_d = ST_SHIFT;
        cnt_d   = 5'd0;
      end
      ST_SHIFT: begin
        shreg_d = {SI, shreg_q[17:1]};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'(UNLOCK_BITS - 1)) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        rx_d    = shreg_q;
        busy_d  = 1'b0;
        // a failed compare never clears an earlier unlock
        if (shreg_q == PATTERN) begin
          done_d = 1'b1;
          unl_d  = 1'b1;
        end else begin
          fail_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      shreg_q <= 18'h00000;
      addr_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      unl_q   <= 1'b0;
      rx_q    <= 18'h00000;
`ifdef BANDAI_UNLOCK_CART_RESET_EN
      crst_cnt_q <= '0;
      crst_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      unl_q   <= unl_d;
      rx_q    <= rx_d;
`ifdef BANDAI_UNLOCK_CART_RESET_EN
      crst_cnt_q <= crst_cnt_d;
      crst_q     <= crst_d;
`endif
    end
  end

  assign ADDR_O   = addr_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign FAIL     = fail_q;
  assign UNLOCKED = unl_q;
  assign RX_WORD  = rx_q;

endmodule

// File: tb/tb_bandai_unlock_rx.sv
// Bench for bandai_unlock_rx: one-shot cartridge model, cycle-timeline reference model, directed + random runs.
`timescale 1ns/1ps
module tb_bandai_unlock_rx;

  localparam logic [17:0] PAT = 18'h05140;
`ifdef BANDAI_UNLOCK_CART_RESET_EN
  localparam int OFF = 4;
`else
  localparam int OFF = 0;
`endif
  localparam int DONE_REL = 21 + OFF;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        SI = 1'b1;
  logic [7:0]  ADDR_O;
  logic        CART_RST, BUSY, DONE, FAIL, UNLOCKED;
  logic [17:0] RX_WORD;

  bandai_unlock_rx dut (
    .CLK(CLK), .RST(RST), .START(START), .SI(SI),
    .ADDR_O(ADDR_O), .CART_RST(CART_RST), .BUSY(BUSY), .DONE(DONE),
    .FAIL(FAIL), .UNLOCKED(UNLOCKED), .RX_WORD(RX_WORD)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cartridge: answers one request with the unlock word after each of its resets, then all ones.
  bit          armed = 1'b1;
  bit          cart_active = 1'b0;
  int          cart_idx = 0;
  logic [17:0] cart_word = 18'h3FFFF;
  bit          ovr_valid = 1'b0;
  logic [17:0] ovr_word = 18'h0;
  logic [17:0] sent_word = 18'h0;

  always @(negedge CLK or posedge RST) begin
    if (RST) begin
      armed = 1'b1;
      cart_active = 1'b0;
      SI = 1'b1;
    end else begin
      if (CART_RST) armed = 1'b1;
      if (cart_active) begin
        SI = cart_word[cart_idx];
        cart_idx++;
        if (cart_idx == 18) cart_active = 1'b0;
      end else begin
        SI = 1'b1;
      end
      if (ADDR_O == 8'hA5) begin
        if (ovr_valid) begin
          cart_word = ovr_word;
          ovr_valid = 1'b0;
        end else begin
          cart_word = armed ? PAT : 18'h3FFFF;
        end
        armed = 1'b0;
        sent_word = cart_word;
        cart_active = 1'b1;
        cart_idx = 0;
      end
    end
  end

  // Reference timeline: m_rel = cycles since the accepting START edge (-1 when idle).
  int          m_rel = -1;
  bit          m_unl = 1'b0;
  bit          m_match = 1'b0;
  logic [17:0] m_rx = 18'h0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_rel = -1; m_unl = 1'b0; m_match = 1'b0; m_rx = 18'h0;
    end else if ((m_rel < 0 || m_rel == DONE_REL) && START) begin
      m_rel = 1;
    end else if (m_rel > 0 && m_rel < DONE_REL) begin
      m_rel++;
      if (m_rel == DONE_REL) begin
        m_rx = sent_word;
        m_match = (sent_word == PAT);
        if (m_match) m_unl = 1'b1;
      end
    end else begin
      m_rel = -1;
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      chk("addr",     32'(ADDR_O),   (m_rel == 1 + OFF) ? 32'hA5 : 32'h0);
      chk("cart_rst", 32'(CART_RST), 32'(m_rel >= 1 && m_rel <= OFF));
      chk("busy",     32'(BUSY),     32'(m_rel >= 1 && m_rel < DONE_REL));
      chk("done",     32'(DONE),     32'(m_rel == DONE_REL && m_match));
      chk("fail",     32'(FAIL),     32'(m_rel == DONE_REL && !m_match));
      chk("unlocked", 32'(UNLOCKED), 32'(m_unl));
      chk("rx_word",  32'(RX_WORD),  32'(m_rx));
    end
  end

  task automatic start_now();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    start_now();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},     32'(ADDR_O),   32'h0);
    chk({tag, "_cart_rst"}, 32'(CART_RST), 32'h0);
    chk({tag, "_busy"},     32'(BUSY),     32'h0);
    chk({tag, "_done"},     32'(DONE),     32'h0);
    chk({tag, "_fail"},     32'(FAIL),     32'h0);
    chk({tag, "_unlocked"}, 32'(UNLOCKED), 32'h0);
    chk({tag, "_rx"},       32'(RX_WORD),  32'h0);
  endtask

  // Called at the negedge of cycle 1; n counts cycles after the START edge.
  task automatic wait_end(input int spur_at, output int n, output bit d, output bit f,
                          output int req_n, output int crst_n);
    n = 1; d = 1'b0; f = 1'b0; req_n = -1; crst_n = 0;
    forever begin
      START = (n == spur_at);
      if (ADDR_O == 8'hA5 && req_n < 0) req_n = n;
      if (CART_RST) crst_n++;
      if (DONE || FAIL) begin
        d = DONE; f = FAIL;
        break;
      end
      if (n >= 200) begin
        checks++; errors++;
        $display("FAIL wait_end: no DONE/FAIL after %0d cycles, expected at %0d", n, DONE_REL);
        n = -1;
        break;
      end
      @(negedge CLK);
      n++;
    end
    START = 1'b0;
  endtask

  int n, req_n, crst_n, extra;
  bit d, f;

  initial begin
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk_reset_vals("reset");
    RST = 1'b0;

    // first handshake after reset: pattern, DONE at cycle 21 (+OFF)
    pulse_start();
    wait_end(-1, n, d, f, req_n, crst_n);
    chk("t1_latency", n, DONE_REL);
    chk("t1_req_cycle", req_n, 1 + OFF);
    chk("t1_crst_cycles", crst_n, OFF);
    chk("t1_done", 32'(d), 32'h1);
    chk("t1_rx", 32'(RX_WORD), 32'h05140);
    chk("t1_unlocked", 32'(UNLOCKED), 32'h1);

    // second handshake with no external cartridge reset
    pulse_start();
    wait_end(-1, n, d, f, req_n, crst_n);
    chk("t2_latency", n, DONE_REL);
`ifdef BANDAI_UNLOCK_CART_RESET_EN
    chk("t2_done", 32'(d), 32'h1);
    chk("t2_rx", 32'(RX_WORD), 32'h05140);
    chk("t2_latency_25", n, 25);
`else
    chk("t2_fail", 32'(f), 32'h1);
    chk("t2_rx", 32'(RX_WORD), 32'h3FFFF);
`endif
    chk("t2_unlocked", 32'(UNLOCKED), 32'h1);

    // bit 9 corrupted on a freshly reset system
    do_reset();
    ovr_word = PAT ^ 18'h00200;
    ovr_valid = 1'b1;
    pulse_start();
    wait_end(-1, n, d, f, req_n, crst_n);
    chk("t4_fail", 32'(f), 32'h1);
    chk("t4_rx", 32'(RX_WORD), 32'h05340);
    chk("t4_unlocked", 32'(UNLOCKED), 32'h0);

    // START re-pulsed at cycle 10 while busy
    do_reset();
    pulse_start();
    wait_end(10, n, d, f, req_n, crst_n);
    chk("t5_done", 32'(d), 32'h1);
    chk("t5_latency", n, DONE_REL);
    extra = 0;
    repeat (30) begin
      @(negedge CLK);
      if (DONE || FAIL) extra++;
    end
    chk("t5_extra_pulses", extra, 0);

    // asynchronous reset during the 8th SHIFT cycle, then a normal handshake
    pulse_start();
    repeat (8 + OFF) @(negedge CLK);
    chk("t6_busy_before_rst", 32'(BUSY), 32'h1);
    #2 RST = 1'b1;
    #1 chk_reset_vals("t6_async");
    @(negedge CLK);
    RST = 1'b0;
    pulse_start();
    wait_end(-1, n, d, f, req_n, crst_n);
    chk("t6_done", 32'(d), 32'h1);
    chk("t6_rx", 32'(RX_WORD), 32'h05140);
    chk("t6_latency", n, DONE_REL);

    // randomized runs, checked every cycle by the reference timeline
    for (int it = 0; it < 40; it++) begin
      int r, gap, spur;
      r = $urandom_range(0, 3);
      case (r)
        0: begin ovr_word = PAT; ovr_valid = 1'b1; end
        1: begin ovr_word = 18'($urandom); ovr_valid = 1'b1; end
        2: begin ovr_word = PAT ^ (18'h1 << $urandom_range(0, 17)); ovr_valid = 1'b1; end
        default: ovr_valid = 1'b0;
      endcase
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge CLK);
      start_now();
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, DONE_REL)) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
      end else begin
        spur = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, DONE_REL - 1)) : -1;
        wait_end(spur, n, d, f, req_n, crst_n);
        chk("rand_latency", n, DONE_REL);
      end
    end

    repeat (5) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
